// File: rtl/ats_token_bucket_gate.sv
// ats_token_bucket_gate: token-bucket shaper that holds each stored frame until enough credit exists.
// Ports:
//   clk, rstn                         clock, synchronous active-low reset
//   s_axis_*                          frame bytes (may carry a timestamp footer), forwarded up to tlast
//   s_axis_frame_length_*             one length per frame in bytes, footer excluded
//   m_axis_*                          gated frame output; tdata/tlast are combinational pass-throughs
//   cfg_cir_increment, cfg_cbs        refill per clock (fixed point, FRAC_BITS fraction) and bucket size in bytes
//   token_level, drop_pulse           current credit; one-cycle pulse on the tlast of a dropped oversize frame
// Optional macro ATS_TOKEN_BUCKET_GATE_STATS_EN adds stat_passed_frames, stat_dropped_frames, stat_wait_cycles.
module ats_token_bucket_gate #(
  parameter int DATA_WIDTH         = 8,
  parameter int FRAME_LENGTH_WIDTH = 16,
  parameter int FRAC_BITS          = 8,
  parameter int TOKEN_WIDTH        = FRAME_LENGTH_WIDTH + FRAC_BITS
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  input  logic [FRAME_LENGTH_WIDTH-1:0] s_axis_frame_length_tdata,
  input  logic                          s_axis_frame_length_tvalid,
  output logic                          s_axis_frame_length_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  input  logic [TOKEN_WIDTH-1:0]        cfg_cir_increment,
  input  logic [FRAME_LENGTH_WIDTH-1:0] cfg_cbs,
  output logic [TOKEN_WIDTH-1:0]        token_level,
  output logic                          drop_pulse
`ifdef ATS_TOKEN_BUCKET_GATE_STATS_EN
  ,
  output logic [31:0]                   stat_passed_frames,
  output logic [31:0]                   stat_dropped_frames,
  output logic [31:0]                   stat_wait_cycles
`endif
);
  typedef enum logic [1:0] {IDLE, CHECK, FORWARD, DROP} state_t;
  state_t                        state_q, state_d;
  logic [TOKEN_WIDTH-1:0]        tokens_q, tokens_d, need;
  logic [FRAME_LENGTH_WIDTH-1:0] len_q, len_d;
  logic [TOKEN_WIDTH:0]          cap, sum;
  logic                          oversize, enough, deduct;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tlast  = s_axis_tlast;
  assign token_level   = tokens_q;
  assign need          = TOKEN_WIDTH'({len_q, {FRAC_BITS{1'b0}}});
  assign cap           = (TOKEN_WIDTH+1)'({cfg_cbs, {FRAC_BITS{1'b0}}});
  assign oversize      = len_q > cfg_cbs;
  assign enough        = tokens_q >= need;
  assign deduct        = state_q == CHECK && !oversize && enough;
  // One extra bit absorbs refill overflow before the clamp; deduct only fires when covered, so no underflow.
  assign sum           = {1'b0, tokens_q} + {1'b0, cfg_cir_increment} - (deduct ? {1'b0, need} : '0);
  assign tokens_d      = sum > cap ? cap[TOKEN_WIDTH-1:0] : sum[TOKEN_WIDTH-1:0];
  always_comb begin
    state_d                    = state_q;
    len_d                      = len_q;
    s_axis_tready              = 1'b0;
    m_axis_tvalid              = 1'b0;
    s_axis_frame_length_tready = 1'b0;
    drop_pulse                 = 1'b0;
    case (state_q)
      IDLE: begin
        s_axis_frame_length_tready = 1'b1;
        len_d   = s_axis_frame_length_tvalid ? s_axis_frame_length_tdata : len_q;
        state_d = s_axis_frame_length_tvalid ? CHECK : IDLE;
      end
      CHECK: state_d = oversize ? DROP : enough ? FORWARD : CHECK;
      FORWARD: begin
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        state_d       = s_axis_tvalid && m_axis_tready && s_axis_tlast ? IDLE : FORWARD;
      end
      DROP: begin
        s_axis_tready = 1'b1;
        drop_pulse    = s_axis_tvalid && s_axis_tlast;
        state_d       = s_axis_tvalid && s_axis_tlast ? IDLE : DROP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      tokens_q <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      tokens_q <= tokens_d;
      len_q    <= len_d;
    end
  end
`ifdef ATS_TOKEN_BUCKET_GATE_STATS_EN
  logic [31:0] passed_q, dropped_q, wait_q;
  assign stat_passed_frames  = passed_q;
  assign stat_dropped_frames = dropped_q;
  assign stat_wait_cycles    = wait_q;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      passed_q  <= '0;
      dropped_q <= '0;
      wait_q    <= '0;
    end else begin
      passed_q  <= passed_q + 32'(state_q == FORWARD && s_axis_tvalid && m_axis_tready && s_axis_tlast);
      dropped_q <= dropped_q + 32'(drop_pulse);
      wait_q    <= wait_q + 32'(state_q == CHECK && state_d == CHECK);
    end
  end
`endif
endmodule

// File: tb/tb_ats_token_bucket_gate.sv
// tb_ats_token_bucket_gate: directed bench for the token-bucket gate with hand-computed token levels.
module tb_ats_token_bucket_gate;
  logic        clk = 1'b0, rstn = 1'b0;
  logic [7:0]  s_tdata = '0, m_tdata;
  logic        s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
  logic [15:0] s_len_tdata = '0;
  logic        s_len_tvalid = 1'b0, s_len_tready;
  logic        m_tvalid, m_tready = 1'b1, m_tlast;
  logic [23:0] inc = 24'd128, tok;
  logic [15:0] cbs = 16'd200;
  logic        drop;
  int          n_chk = 0, n_pass = 0;
  logic [23:0] mx;
  always #5 clk = ~clk;
  ats_token_bucket_gate dut (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .s_axis_frame_length_tdata(s_len_tdata), .s_axis_frame_length_tvalid(s_len_tvalid),
    .s_axis_frame_length_tready(s_len_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .cfg_cir_increment(inc), .cfg_cbs(cbs), .token_level(tok), .drop_pulse(drop)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic give_len(input int len);
    logic hs;
    s_len_tdata = 16'(len); s_len_tvalid = 1'b1;
    s_tvalid = 1'b1; s_tdata = '0; s_tlast = 1'b0;
    for (int k = 0; k <= 100; k++) begin
      if (k == 100) begin check("len_timeout", 1, 0); break; end
      #1 hs = s_len_tready;
      @(posedge clk); #1;
      if (hs) break;
    end
    s_len_tvalid = 1'b0;
    check("gate_closed", {m_tvalid, s_tready}, 0);
  endtask
  task automatic wait_go(input int exp_n, input int exp_tok);
    int n = 0;
    while (n < 5000) begin
      @(posedge clk); #1;
      n++;
      if (m_tvalid || s_tready) break;
    end
    check("wait_cycles", n, exp_n);
    check("tok_at_go", 32'(tok), exp_tok);
  endtask
  task automatic run_beats(input int nb, input bit fwd, input bit toggle, input int stop);
    int  i = 0;
    logic hs;
    for (int it = 0; it < 400 && i < nb && (stop == 0 || i < stop); it++) begin
      m_tready = toggle ? ~m_tready : 1'b1;
      s_tvalid = 1'b1; s_tdata = 8'(i); s_tlast = (i == nb - 1);
      #1;
      check("m_tvalid", m_tvalid, fwd);
      check("s_tready", s_tready, fwd ? m_tready : 1'b1);
      check("drop_pulse", drop, !fwd && s_tlast);
      if (fwd) check("m_tlast", m_tlast, s_tlast);
      hs = s_tvalid && s_tready;
      @(posedge clk); #1;
      if (hs) i++;
    end
    check("beats", i, stop != 0 ? stop : nb);
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 s_tvalid = 1'b1;
    #1;
    check("rst_tok", 32'(tok), 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_len_tready", s_len_tready, 1);
    check("rst_drop", drop, 0);
    rstn = 1'b1;
    give_len(64);
    wait_go(128, 128);
    run_beats(73, 1, 0, 0);
    check("tok_f64_end", 32'(tok), 9472);
    cbs = 16'd20;
    @(posedge clk); #1;
    check("tok_clamp", 32'(tok), 5120);
    cbs = 16'd200;
    mx = '0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (tok > mx) mx = tok;
    end
    check("tok_max", 32'(mx), 51200);
    check("tok_full", 32'(tok), 51200);
    inc = 24'd32;
    give_len(100);
    wait_go(1, 25632);
    run_beats(100, 1, 0, 0);
    check("tok_b1_end", 32'(tok), 28832);
    give_len(100);
    wait_go(1, 3296);
    run_beats(100, 1, 0, 0);
    check("tok_b2_end", 32'(tok), 6496);
    give_len(100);
    wait_go(597, 32);
    run_beats(100, 1, 0, 0);
    check("tok_b3_end", 32'(tok), 3232);
    give_len(300);
    wait_go(1, 3296);
    run_beats(5, 0, 0, 0);
    check("tok_drop_end", 32'(tok), 3456);
    give_len(0);
    wait_go(1, 3520);
    run_beats(3, 1, 0, 0);
    check("tok_len0_end", 32'(tok), 3616);
    give_len(10);
    wait_go(1, 1120);
    run_beats(20, 1, 1, 8);
    rstn = 1'b0; s_tvalid = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_tok", 32'(tok), 0);
    check("mid_rst_len_tready", s_len_tready, 1);
    check("mid_rst_s_tready", s_tready, 0);
    check("mid_rst_m_tvalid", m_tvalid, 0);
    check("mid_rst_drop", drop, 0);
    rstn = 1'b1; s_tvalid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_refill", 32'(tok), 32);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
